// File: rtl/rep_control_wb_if.sv
// Write-back side bundle for the string-repeat controller.
// The master side presents the WB-stage uop; the slave side (the controller)
// returns the repeat pulses and the registered rep_active status.
interface rep_control_wb_if #(
    parameter int COUNT_W = 32,
    parameter int EIP_W   = 32
);
    logic               WB_V;
    logic               WB_FLUSH;
    logic               CS_REP_START_WB;
    logic               CS_ITER_LAST_WB;
    logic [1:0]         CS_REP_MODE_WB;
    logic [COUNT_W-1:0] WB_ECX;
    logic [COUNT_W-1:0] WB_RESULT_C;
    logic               ZF;
    logic [EIP_W-1:0]   WB_EIP;
    logic [EIP_W-1:0]   WB_NEIP;

    logic               rep_active;
    logic               rep_ld_eip;
    logic [EIP_W-1:0]   rep_eip;
    logic               rep_ld_count;
    logic               rep_flush;
    logic               rep_terminate;

    modport master (
        output WB_V, WB_FLUSH, CS_REP_START_WB, CS_ITER_LAST_WB, CS_REP_MODE_WB,
        output WB_ECX, WB_RESULT_C, ZF, WB_EIP, WB_NEIP,
        input  rep_active, rep_ld_eip, rep_eip, rep_ld_count, rep_flush, rep_terminate
    );

    modport slave (
        input  WB_V, WB_FLUSH, CS_REP_START_WB, CS_ITER_LAST_WB, CS_REP_MODE_WB,
        input  WB_ECX, WB_RESULT_C, ZF, WB_EIP, WB_NEIP,
        output rep_active, rep_ld_eip, rep_eip, rep_ld_count, rep_flush, rep_terminate
    );
endinterface

// File: rtl/rep_control_wb.sv
// REP/REPE/REPNE string-instruction sequencing at the write-back stage.
// Decides, on the WB uop, whether to restart the iteration (reload EIP of the
// string instruction and flush younger uops) or to finish (reload the next EIP).
// Optional build macro REP_ITER_CNT_EN adds the rep_iter_cnt completed-iteration
// counter output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no repeat sequence in flight; watching for a start uop
// RUN   | repeat sequence in flight; saved EIP/NEIP/mode govern
module rep_control_wb #(
    parameter int COUNT_W = 32,
    parameter int EIP_W   = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    rep_control_wb_if.slave   wb
`ifdef REP_ITER_CNT_EN
    ,
    output logic [15:0]       rep_iter_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_REPE  = 2'b10;
    localparam logic [1:0] MODE_REPNE = 2'b11;

    localparam logic [COUNT_W-1:0] COUNT_ZERO = '0;

    state_t             state_q;
    state_t             state_d;

    logic [EIP_W-1:0]   saved_eip;
    logic [EIP_W-1:0]   saved_neip;
    logic [1:0]         saved_mode;

    logic               in_idle;
    logic               in_run;
    logic               start;
    logic               ecx_zero;
    logic               res_zero;
    logic               skip;
    logic               iter_end;
    logic               term_cond;
    logic               live;
    logic [1:0]         eff_mode;
    logic [EIP_W-1:0]   eff_eip;
    logic [EIP_W-1:0]   eff_neip;

    // Event decode shared by next-state and output logic. A start that is also
    // the last uop of its iteration is judged with the live WB values, since
    // the saved copies are only written at the end of this cycle.
    assign in_idle   = (state_q == ST_IDLE);
    assign in_run    = (state_q == ST_RUN);
    assign start     = in_idle & wb.WB_V & wb.CS_REP_START_WB
                       & (wb.CS_REP_MODE_WB != MODE_NONE);
    assign ecx_zero  = (wb.WB_ECX == COUNT_ZERO);
    assign res_zero  = (wb.WB_RESULT_C == COUNT_ZERO);
    assign skip      = start & ecx_zero;
    assign iter_end  = (in_run & wb.WB_V & wb.CS_ITER_LAST_WB)
                       | (start & ~ecx_zero & wb.CS_ITER_LAST_WB);
    assign eff_mode  = in_run ? saved_mode : wb.CS_REP_MODE_WB;
    assign eff_eip   = in_run ? saved_eip  : wb.WB_EIP;
    assign eff_neip  = in_run ? saved_neip : wb.WB_NEIP;
    assign term_cond = res_zero
                       | ((eff_mode == MODE_REPE)  & ~wb.ZF)
                       | ((eff_mode == MODE_REPNE) &  wb.ZF);
    // Pulses are suppressed while reset is held and on an external flush.
    assign live      = CLR & ~wb.WB_FLUSH;

    // State register.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an external flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (wb.WB_FLUSH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !ecx_zero && (!wb.CS_ITER_LAST_WB || !term_cond)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (iter_end && term_cond) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Same-cycle pulse outputs; rep_eip falls back to WB_NEIP when idle.
    always_comb begin
        wb.rep_ld_eip    = 1'b0;
        wb.rep_eip       = wb.WB_NEIP;
        wb.rep_ld_count  = 1'b0;
        wb.rep_flush     = 1'b0;
        wb.rep_terminate = 1'b0;
        if (live) begin
            if (skip) begin
                wb.rep_ld_eip    = 1'b1;
                wb.rep_eip       = wb.WB_NEIP;
                wb.rep_terminate = 1'b1;
            end else if (iter_end) begin
                wb.rep_ld_count = 1'b1;
                wb.rep_ld_eip   = 1'b1;
                if (term_cond) begin
                    wb.rep_eip       = eff_neip;
                    wb.rep_terminate = 1'b1;
                end else begin
                    wb.rep_eip   = eff_eip;
                    wb.rep_flush = 1'b1;
                end
            end
        end
    end

    assign wb.rep_active = in_run;

    // Capture the string instruction's context when a sequence starts.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            saved_eip  <= '0;
            saved_neip <= '0;
            saved_mode <= MODE_NONE;
        end else if (start) begin
            saved_eip  <= wb.WB_EIP;
            saved_neip <= wb.WB_NEIP;
            saved_mode <= wb.CS_REP_MODE_WB;
        end
    end

`ifdef REP_ITER_CNT_EN
    // Completed-iteration counter: cleared on start, saturating, held after the end.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rep_iter_cnt <= 16'h0000;
        end else if (start && !wb.WB_FLUSH) begin
            rep_iter_cnt <= iter_end ? 16'h0001 : 16'h0000;
        end else if (iter_end && !wb.WB_FLUSH && (rep_iter_cnt != 16'hFFFF)) begin
            rep_iter_cnt <= rep_iter_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/rep_control_wb.md
REP_CONTROL_WB -- requirements
Module: rep_control_wb

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of the count operands.
REQ-002 SHALL have parameter EIP_W, default 32, width of all EIP values.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port CLR  input  1  asynchronous active-low reset.
REQ-005 SHALL have port WB_V  input  1  WB stage holds a valid uop.
REQ-006 SHALL have port WB_FLUSH  input  1  external pipeline flush (interrupt/redirect).
REQ-007 SHALL have port CS_REP_START_WB  input  1  first uop of a string instruction.
REQ-008 SHALL have port CS_ITER_LAST_WB  input  1  last uop of one iteration.
REQ-009 SHALL have port CS_REP_MODE_WB  input  2  00 none, 01 REP, 10 REPE, 11 REPNE.
REQ-010 SHALL have port WB_ECX  input  COUNT_W  count before this uop.
REQ-011 SHALL have port WB_RESULT_C  input  COUNT_W  count after decrement.
REQ-012 SHALL have port ZF  input  1  zero flag after this uop's flag update.
REQ-013 SHALL have port WB_EIP  input  EIP_W  EIP of the string instruction.
REQ-014 SHALL have port WB_NEIP  input  EIP_W  EIP following the instruction.
REQ-015 SHALL have port rep_active  output  1  registered; high in RUN.
REQ-016 SHALL have port rep_ld_eip  output  1  load EIP this cycle.
REQ-017 SHALL have port rep_eip  output  EIP_W  EIP value to load.
REQ-018 SHALL have port rep_ld_count  output  1  write WB_RESULT_C to ECX.
REQ-019 SHALL have port rep_flush  output  1  flush younger uops, iteration restarts.
REQ-020 SHALL have port rep_terminate  output  1  repeat sequence ends this cycle.

Function
REQ-021 SHALL implement states IDLE and RUN; rep_ld_eip/rep_ld_count/rep_flush/rep_terminate SHALL be combinational, same cycle as the WB uop.
REQ-022 IDLE, start = WB_V & CS_REP_START_WB & mode!=00: SHALL latch WB_EIP, WB_NEIP and mode into saved_eip, saved_neip, saved_mode.
REQ-023 Start with WB_ECX==0: SHALL assert rep_ld_eip, rep_eip=WB_NEIP, rep_terminate, and remain IDLE (zero-count skip; no rep_ld_count).
REQ-024 Start with WB_ECX!=0 and CS_ITER_LAST_WB low: SHALL go to RUN next cycle.
REQ-025 Start with CS_ITER_LAST_WB also high (single-uop iteration): SHALL evaluate the end-of-iteration rule (REQ-026..028) in the same cycle, using WB_EIP/WB_NEIP/mode directly.
REQ-026 End of iteration (RUN, WB_V & CS_ITER_LAST_WB): SHALL assert rep_ld_count; terminate = (WB_RESULT_C==0) | (REPE & ~ZF) | (REPNE & ZF); REP ignores ZF.
REQ-027 Terminate: SHALL assert rep_ld_eip, rep_eip=saved_neip, rep_terminate; next state IDLE.
REQ-028 No terminate: SHALL assert rep_ld_eip, rep_eip=saved_eip, rep_flush; stay RUN.
REQ-029 In RUN, CS_REP_MODE_WB and CS_REP_START_WB SHALL be ignored; saved_mode governs.
REQ-030 WB_V low: no output pulses, no state change.
REQ-031 WB_FLUSH high: SHALL force all pulse outputs low and next state IDLE, overriding any same-cycle event.
REQ-032 Count compare SHALL use full COUNT_W; no wrap-around when WB_ECX==0 at start (REQ-023 covers it).
REQ-033 rep_eip SHALL equal WB_NEIP when no pulse is asserted.

Reset
REQ-034 CLR low SHALL asynchronously force state IDLE, saved_eip/saved_neip/saved_mode to 0, rep_active 0; combinational outputs SHALL be low during reset.
REQ-035 Reset in RUN SHALL abandon the sequence with no rep_terminate pulse.

Configuration
REQ-036 Macro REP_ITER_CNT_EN: when defined, SHALL add output rep_iter_cnt [15:0], cleared on start, incremented (saturating at 16'hFFFF) per completed iteration, held after termination, reset to 0 by CLR.
REQ-037 Without REP_ITER_CNT_EN the port and its counter SHALL not exist; other behaviour is identical.

Verification
REQ-038 REP, WB_ECX=3, RESULT_C 2,1,0 over three iteration ends -> two rep_flush with rep_eip=saved_eip, third rep_terminate with rep_eip=saved_neip, rep_active low after.
REQ-039 REPNE, WB_ECX=5, ZF=1 on first iteration end (RESULT_C=4) -> rep_terminate, rep_eip=WB_NEIP, rep_ld_count=1.
REQ-040 REPE start with WB_ECX=0 -> same-cycle rep_terminate, rep_ld_eip, rep_eip=WB_NEIP, rep_ld_count=0, state stays IDLE.
REQ-041 RUN, WB_FLUSH with CS_ITER_LAST_WB in same cycle -> no pulses, next state IDLE.
REQ-042 CLR low mid-RUN for 1 cycle -> rep_active 0 immediately, no pulses; next start behaves normally.
REQ-043 With REP_ITER_CNT_EN, REP WB_ECX=4 full run -> rep_iter_cnt=4 after termination.
